// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised, glitch-filtered clock, framed byte checks,
// stall timeout, optional E0/F0 prefix folding, and a first-word-fall-through output FIFO.
module ps2_rx_fifo #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int FILTER_LEN    = 8,
    parameter int TIMEOUT_US    = 2000,
    parameter int FIFO_DEPTH    = 16,
    parameter int DECODE_PREFIX = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          m_valid,
    output logic [9:0]                    m_data,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          timeout_err,
    output logic                          overflow
);

    localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int FW = $clog2(FILTER_LEN);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_STOP} state_t;

    logic [1:0]    r_clk_s;
    logic [1:0]    r_dat_s;
    logic          r_filt;
    logic          r_filt_d;
    logic [FW-1:0] r_fcnt;
    logic          w_fall;
    logic          w_dat;

    state_t        r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_tcnt;
    logic          r_byte_ok;
    logic [7:0]    r_byte;
    logic          r_ext;
    logic          r_brk;

    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [CW-1:0] r_wptr;
    logic [CW-1:0] r_rptr;
    logic [9:0]    r_last;
    logic          w_is_prefix;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic [9:0]    w_din;

    // The filtered level flips only on the FILTER_LEN-th consecutive differing sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_s  <= 2'b11;
            r_dat_s  <= 2'b11;
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_clk_s  <= {r_clk_s[0], ps2_clk};
            r_dat_s  <= {r_dat_s[0], ps2_data};
            r_filt_d <= r_filt;
            if (r_clk_s[1] == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
                r_filt <= r_clk_s[1];
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + FW'(1);
            end
        end
    end

    assign w_fall = r_filt_d & ~r_filt;
    assign w_dat  = r_dat_s[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_tcnt      <= '0;
            r_byte_ok   <= 1'b0;
            r_byte      <= '0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r_byte_ok   <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            if (w_fall) begin
                r_tcnt <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (!w_dat) begin
                            r_state  <= S_SHIFT;
                            r_bitcnt <= '0;
                        end
                    end
                    S_SHIFT: begin
                        r_shift  <= {w_dat, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par   <= w_dat;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (!w_dat) begin
                            frame_err <= 1'b1;
                        end else if (!(^{r_shift, r_par})) begin
                            parity_err <= 1'b1;
                        end else begin
                            r_byte_ok <= 1'b1;
                            r_byte    <= r_shift;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    timeout_err <= 1'b1;
                    r_state     <= S_IDLE;
                    r_tcnt      <= '0;
                end else begin
                    r_tcnt <= r_tcnt + TW'(1);
                end
            end else begin
                r_tcnt <= '0;
            end
        end
    end

    assign w_is_prefix = (DECODE_PREFIX != 0) && ((r_byte == 8'hE0) || (r_byte == 8'hF0));
    assign w_push      = r_byte_ok & ~w_is_prefix;
    assign w_din       = (DECODE_PREFIX != 0) ? {r_ext, r_brk, r_byte} : {2'b00, r_byte};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_byte_ok && (DECODE_PREFIX != 0)) begin
            if (r_byte == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (r_byte == 8'hF0) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    assign fifo_count = r_wptr - r_rptr;
    assign m_valid    = (fifo_count != '0);
    assign w_full     = (fifo_count == CW'(FIFO_DEPTH));
    assign w_pop      = m_valid & m_ready;
    // A pop frees the head slot in the same cycle, so a push into a full FIFO still lands.
    assign w_wr       = w_push & (~w_full | w_pop);
    assign m_data     = m_valid ? r_mem[r_rptr[AW-1:0]] : r_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_last   <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr[AW-1:0]] <= w_din;
                r_wptr                <= r_wptr + CW'(1);
            end
            if (w_push && w_full && !w_pop) overflow <= 1'b1;
            if (w_pop) begin
                r_rptr <= r_rptr + CW'(1);
                r_last <= r_mem[r_rptr[AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames are driven at PS/2 pin level, a queue model predicts
// the FIFO contents, and a compare process checks pops and idle-time state every cycle.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 4;
    localparam int H     = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       m_ready = 1'b0;
    logic       m_valid;
    logic [9:0] m_data;
    logic [$clog2(DEPTH):0] fifo_count;
    logic       parity_err, frame_err, timeout_err, overflow;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .CLK_HZ(1_000_000), .FILTER_LEN(8), .TIMEOUT_US(200),
        .FIFO_DEPTH(DEPTH), .DECODE_PREFIX(1)
    ) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .fifo_count(fifo_count),
        .parity_err(parity_err), .frame_err(frame_err), .timeout_err(timeout_err),
        .overflow(overflow)
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_par = 0, n_frm = 0, n_to = 0;
    bit chk_en = 1'b0;

    logic [9:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    logic [9:0] exp_last = '0;
    logic       mdl_ext = 1'b0, mdl_brk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Prefix folding and FIFO admission, at byte level.
    task automatic model_byte(input logic [7:0] b, input bit coincident_pop);
        if (b == 8'hE0) mdl_ext = 1'b1;
        else if (b == 8'hF0) mdl_brk = 1'b1;
        else begin
            if (exp_q.size() < DEPTH || coincident_pop) exp_q.push_back({mdl_ext, mdl_brk, b});
            else exp_ovf = 1'b1;
            mdl_ext = 1'b0;
            mdl_brk = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (parity_err)  n_par++;
                if (frame_err)   n_frm++;
                if (timeout_err) n_to++;
                if (chk_en) begin
                    check("count", fifo_count, exp_q.size());
                    check("overflow", overflow, exp_ovf);
                    check("valid", m_valid, exp_q.size() != 0);
                    check("head", m_data, (exp_q.size() != 0) ? exp_q[0] : exp_last);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) check("pop_unexpected", m_valid, 1'b0);
                    else begin
                        check("pop_data", m_data, exp_q[0]);
                        exp_last = exp_q.pop_front();
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        chk_en = 1'b1;
        repeat (n) @(negedge clk);
        chk_en = 1'b0;
    endtask

    // nbits < 11 sends a truncated frame; sync_pop pulses m_ready on the cycle the byte is pushed.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit glitch, input bit sync_pop);
        logic [10:0] bits;
        bit good;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        good = !bad_par && !bad_stop && (nbits == 11);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (glitch) begin
                repeat (6) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (5) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (9) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            ps2_clk = 1'b0;
            if (i == 10 && good) model_byte(b, sync_pop);
            for (int k = 1; k <= H; k++) begin
                @(negedge clk);
                if (sync_pop && i == 10 && k == 11) m_ready = 1'b1;
                if (sync_pop && i == 10 && k == 12) m_ready = 1'b0;
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11, 1'b0, 1'b0);
    endtask

    initial begin
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", m_valid, 1'b0);
        check("rst_data", m_data, 10'h000);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 1'b0);
        idle(5);

        m_ready = 1'b1;
        send(8'h1C);
        idle(10);
        check("t1_data", m_data, 10'h01C);
        check("t1_errs", n_par + n_frm + n_to, 0);

        send(8'hE0); send(8'hF0); send(8'h75);
        idle(10);
        check("t2_folded", m_data, 10'h375);
        send(8'h75);
        idle(10);
        check("t2_plain", m_data, 10'h075);

        send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0, 1'b0);
        idle(10);
        check("t3_par", n_par, 1);
        check("t3_frm0", n_frm, 0);
        check("t3_count", fifo_count, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
        idle(10);
        check("t3_frm", n_frm, 1);
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
        idle(10);
        check("t3_both_frm", n_frm, 2);
        check("t3_both_par", n_par, 1);

        send_frame(8'h1C, 1'b0, 1'b0, 5, 1'b0, 1'b0);
        idle(400);
        check("t4_to", n_to, 1);
        send(8'h2A);
        idle(10);
        check("t4_next", m_data, 10'h02A);

        ps2_data = 1'b0;
        for (int g = 0; g < 3; g++) begin
            ps2_clk = 1'b0;
            repeat (5) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        ps2_data = 1'b1;
        idle(300);
        check("t6_glitch_to", n_to, 1);
        send_frame(8'h5A, 1'b0, 1'b0, 11, 1'b1, 1'b0);
        idle(10);
        check("t6_glitch_frame", m_data, 10'h05A);
        check("t6_glitch_errs", n_frm + n_par, 3);

        m_ready = 1'b0;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        idle(10);
        check("t5_full", fifo_count, DEPTH);
        check("t5_noovf", overflow, 1'b0);
        check("t5_head", m_data, 10'h011);
        send_frame(8'h55, 1'b0, 1'b0, 11, 1'b0, 1'b1);
        idle(10);
        check("t5_sync_count", fifo_count, DEPTH);
        check("t5_sync_ovf", overflow, 1'b0);
        check("t5_sync_head", m_data, 10'h022);
        send(8'h66);
        idle(10);
        check("t5_ovf", overflow, 1'b1);
        check("t5_ovf_head", m_data, 10'h022);
        m_ready = 1'b1;
        idle(10);
        check("t5_drained", fifo_count, 0);
        check("t5_hold", m_data, 10'h055);

        m_ready = 1'b0;
        send(8'hE0); send(8'h12); send(8'hF0);
        idle(5);
        check("t6_pre_head", m_data, 10'h212);
        send_frame(8'h34, 1'b0, 1'b0, 6, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #2;
        check("t6_rst_valid", m_valid, 1'b0);
        check("t6_rst_data", m_data, 10'h000);
        check("t6_rst_count", fifo_count, 0);
        check("t6_rst_ovf", overflow, 1'b0);
        check("t6_rst_pulses", {parity_err, frame_err, timeout_err}, 3'b000);
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_last = '0;
        mdl_ext = 1'b0;
        mdl_brk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(300);
        check("t6_no_to", n_to, 1);
        m_ready = 1'b1;
        send(8'h75);
        idle(10);
        check("t6_flags_clear", m_data, 10'h075);
        check("t6_err_total", n_par + n_frm + n_to, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
